// File: rtl/fq_vc_scheduler.sv
// fq_vc_scheduler: output-side VC scheduler for a flit queue.
// Keeps a downstream credit counter per VC, round-robin arbitrates among VCs
// that have a head flit and a credit, pops the winner with a one-hot dequeue
// and holds the granted flit on a registered valid/ack output port.
// Optional build macro: FQ_SCHED_STATS_EN enables the credit-starvation
// stall counter; without it stall_count_o is tied to zero.

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 8
`endif

// Per-VC downstream credit counter with saturating return.
module fq_vc_credit #(
  parameter int CREDIT_MAX = 5,
  parameter int CW         = 3
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          ovf_o
);
  logic [CW-1:0] count_q, count_d;

  assign full_o  = (count_q == CW'(CREDIT_MAX));
  // A return with no matching grant while already full is a protocol error.
  assign ovf_o   = inc_i & ~dec_i & full_o;
  assign count_o = count_q;

  // Next count: a grant and a return in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !full_o)
      count_d = count_q + CW'(1);
    else if (dec_i && !inc_i)
      count_d = count_q - CW'(1);
  end

  // Counter register, starts with the full downstream buffer depth.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) count_q <= CW'(CREDIT_MAX);
    else         count_q <= count_d;
  end
endmodule

module fq_vc_scheduler #(
  parameter int LOG_NVCS   = 1,
  parameter int CREDIT_MAX = 5,
  parameter int CW         = 3
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic                              enable_i,
  input  logic [(1<<LOG_NVCS)*`FLIT_WIDTH-1:0] flit_in_i,
  input  logic [(1<<LOG_NVCS)-1:0]          flit_in_valid_i,
  output logic [(1<<LOG_NVCS)-1:0]          dequeue_o,
  output logic [`FLIT_WIDTH-1:0]            flit_out_o,
  output logic                              flit_out_valid_o,
  output logic [LOG_NVCS-1:0]               flit_out_vc_o,
  input  logic                              flit_out_ack_i,
  input  logic                              credit_in_valid_i,
  input  logic [LOG_NVCS-1:0]               credit_in_vc_i,
  output logic                              error_o,
  output logic                              is_quiescent_o,
  output logic [15:0]                       stall_count_o
);
  localparam int NVCS = 1 << LOG_NVCS;
  localparam int FW   = `FLIT_WIDTH;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                      state_q;
  logic [FW-1:0]               flit_q;
  logic [LOG_NVCS-1:0]         vc_q;
  logic [LOG_NVCS-1:0]         last_q;
  logic                        error_q;

  logic [NVCS-1:0][CW-1:0]     credit;
  logic [NVCS-1:0]             cr_full;
  logic [NVCS-1:0]             cr_ovf;
  logic [NVCS-1:0]             cr_inc;
  logic [NVCS-1:0]             eligible;
  logic                        slot_free;
  logic                        grant;
  logic                        found;
  logic [LOG_NVCS-1:0]         win;
  logic [LOG_NVCS-1:0]         idx;

  // Per-VC credit counters; a grant decrements only the winner.
  for (genvar v = 0; v < NVCS; v++) begin : g_vc
    assign cr_inc[v]   = credit_in_valid_i & (credit_in_vc_i == LOG_NVCS'(v));
    assign eligible[v] = flit_in_valid_i[v] & (credit[v] != '0);
    fq_vc_credit #(.CREDIT_MAX(CREDIT_MAX), .CW(CW)) u_cr (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .inc_i   (cr_inc[v]),
      .dec_i   (dequeue_o[v]),
      .count_o (credit[v]),
      .full_o  (cr_full[v]),
      .ovf_o   (cr_ovf[v])
    );
  end

  // The output register can take a new flit when empty or being drained now.
  assign slot_free = (state_q == S_IDLE) | flit_out_ack_i;
  assign grant     = enable_i & slot_free & (|eligible);

  // Round-robin search starting just after the last winner; NVCS is a power
  // of two, so truncating the sum is the modulo wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NVCS; k++) begin
      idx = last_q + LOG_NVCS'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign dequeue_o = grant ? (NVCS'(1) << win) : '0;

  // Output FSM: load on grant, drain to IDLE on ack without a new grant,
  // and record sticky protocol errors (stray ack, credit overflow).
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      flit_q  <= '0;
      vc_q    <= '0;
      last_q  <= LOG_NVCS'(NVCS - 1);
      error_q <= 1'b0;
    end else begin
      if ((flit_out_ack_i && state_q == S_IDLE) || (|cr_ovf))
        error_q <= 1'b1;
      if (grant) begin
        state_q <= S_HOLD;
        flit_q  <= flit_in_i[win*FW +: FW];
        vc_q    <= win;
        last_q  <= win;
      end else if (state_q == S_HOLD && flit_out_ack_i) begin
        state_q <= S_IDLE;
      end
    end
  end

  assign flit_out_o       = flit_q;
  assign flit_out_vc_o    = vc_q;
  assign flit_out_valid_o = (state_q == S_HOLD);
  assign error_o          = error_q;
  assign is_quiescent_o   = (state_q == S_IDLE) & (&cr_full);

`ifdef FQ_SCHED_STATS_EN
  logic        stall_cond;
  logic [15:0] stall_q;

  // Slot is free and a flit is waiting, but every waiting VC lacks credit.
  assign stall_cond = enable_i & slot_free & (|flit_in_valid_i) & ~(|eligible);

  // Saturating credit-starvation counter.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                              stall_q <= '0;
    else if (stall_cond && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_count_o = stall_q;
`else
  assign stall_count_o = '0;
`endif
endmodule

// File: doc/fq_vc_scheduler.md
Name: fq_vc_scheduler

Overview:
- Output-side VC scheduler for a flit queue with NVCS virtual-channel outputs.
- Tracks downstream credits per VC and round-robin arbitrates among VCs that have a flit and at least one credit.
- Pulses the one-hot dequeue for the winning VC and presents the winning flit on a single registered output port with a valid/ack handshake.
- Sits between the flit queue's per-VC outputs and the router output link; credits returned by the downstream input unit replenish its counters.

Parameters:
- LOG_NVCS, 1, log2 of the VC count; NVCS = 1 << LOG_NVCS.
- CREDIT_MAX, 5, per-VC downstream buffer depth; also the counter reset value.
- CW, 3, credit counter width; must satisfy CREDIT_MAX < 2^CW.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  gates new grants only.
- flit_in  in  NVCS*`FLIT_WIDTH  per-VC head flits; VC v occupies bits [v*`FLIT_WIDTH +: `FLIT_WIDTH].
- flit_in_valid  in  NVCS  per-VC head-valid flags.
- dequeue  out  NVCS  one-hot pop pulse to the flit queue.
- flit_out  out  `FLIT_WIDTH  registered granted flit.
- flit_out_valid  out  1  output holds a flit.
- flit_out_vc  out  LOG_NVCS  VC of flit_out.
- flit_out_ack  in  1  consumer accepts flit_out this cycle.
- credit_in_valid  in  1  one credit returned this cycle.
- credit_in_vc  in  LOG_NVCS  VC of the returned credit.
- error  out  1  sticky protocol error.
- is_quiescent  out  1  no flit held and all counters equal CREDIT_MAX.
- stall_count  out  16  see Optional Feature.

Behaviour:
- Reset values:
  - dequeue = 0, flit_out = 0, flit_out_valid = 0, flit_out_vc = 0.
  - error = 0, stall_count = 0.
  - credit[v] = CREDIT_MAX for every VC; round-robin pointer last = NVCS-1 (VC 0 has first priority).
- States: IDLE (flit_out_valid=0) and HOLD (flit_out_valid=1).
- Eligibility: eligible[v] = flit_in_valid[v] & (credit[v] != 0).
- Slot free: slot_free = IDLE | (HOLD & flit_out_ack).
- Grant condition: grant = enable & slot_free & |eligible.
- Winner selection: the first eligible VC searching last+1, last+2, ... modulo NVCS.
- On grant, the winner is w:
  - dequeue[w] = 1 in the same cycle (combinational, exactly one bit).
  - Next edge: flit_out <= flit_in[w], flit_out_vc <= w, state <= HOLD, last <= w, credit[w] decrements.
- Latency: a flit offered in cycle N is visible on flit_out in cycle N+1.
- Back-to-back: ack plus a new grant in the same cycle keeps HOLD with the new flit, giving 1 flit/cycle sustained.
- HOLD & flit_out_ack & no grant: state <= IDLE next edge.
- HOLD & no ack: flit_out and flit_out_vc stay stable and no grant is issued.
- flit_out_ack while IDLE: ignored and sets error.
- Credit return:
  - On credit_in_valid, credit[credit_in_vc] increments.
  - A same-cycle grant decrement on the same VC nets to zero change.
  - An increment that would exceed CREDIT_MAX saturates at CREDIT_MAX and sets error.
  - Credits are accepted regardless of enable.
- enable=0: no grants and dequeue=0; HOLD and ack handling continue normally.
- error is sticky until reset.
- Asserting reset while in HOLD drops flit_out_valid immediately; the held flit is lost. The flit queue entry was already popped, so this is the caller's responsibility.

Optional Feature:
- Macro: FQ_SCHED_STATS_EN.
- Defined:
  - stall_count increments each cycle where enable & slot_free & (|flit_in_valid) & ~(|eligible), i.e. credit starvation.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined: stall_count is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset with VC0 valid and flit_in VC0=0xA5, ack held high: dequeue=01 in the first enabled cycle; next cycle flit_out=0xA5, flit_out_vc=0, credit[0]=4.
- Both VCs valid continuously, ack=1, no credit returns, CREDIT_MAX=5: grants alternate VC0,VC1,...; 10 flits total, then dequeue stays 0 and, with FQ_SCHED_STATS_EN defined, stall_count increments by 1 per cycle.
- HOLD with ack=0 for 3 cycles and VC1 valid: flit_out stable, dequeue=0; on the ack cycle dequeue=10, and the next cycle shows the VC1 flit with no bubble.
- Credit for VC0 returned in the same cycle VC0 is granted with credit[0]=1: credit[0] stays 1, no error.
- Credit returned for VC1 while credit[1]=5: credit stays 5 and error rises, staying 1 until reset.
- enable=0 with VC0 valid: no dequeue; a credit return still increments its counter; ack on a held flit still moves the state to IDLE.
